// File: rtl/legv8_pkg.sv
// Shared LEGv8 decode constants, R-type field layout and EX-side control bundle.
// Used by the ID/issue stage and its register scoreboard.
package legv8_pkg;

  localparam int XLEN = 64;
  localparam int NREGS = 32;
  localparam logic [4:0] XZR = 5'd31;

  localparam logic [10:0] OP_ADD = 11'b10001011000;
  localparam logic [10:0] OP_SUB = 11'b11001011000;
  localparam logic [10:0] OP_AND = 11'b10001010000;
  localparam logic [10:0] OP_ORR = 11'b10101010000;

  localparam logic [1:0] ALUOP_NONE  = 2'b00;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  typedef struct packed {
    logic [10:0] opcode;
    logic [4:0]  rm;
    logic [5:0]  shamt;
    logic [4:0]  rn;
    logic [4:0]  rd;
  } rtype_t;

  typedef struct packed {
    logic [10:0] opcode;
    logic [1:0]  alu_op;
    logic [4:0]  write_reg;
    logic        reg_write;
  } ex_ctrl_t;

  localparam ex_ctrl_t EX_CTRL_RST = '{
    opcode:    11'd0,
    alu_op:    ALUOP_NONE,
    write_reg: 5'd0,
    reg_write: 1'b0
  };

  function automatic logic is_rtype_alu(input logic [10:0] op);
    logic hit;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_ORR: hit = 1'b1;
      default:                        hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-destination scoreboard: one bit per GPR, set on EX transfer, cleared on write-back.
// Hazard output is combinational from the registered mask plus the instruction held in EX.
module reg_scoreboard
  import legv8_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       set_vld,
  input  logic [4:0] set_reg,
  input  logic       clr_vld,
  input  logic [4:0] clr_reg,
  input  logic       inflight_vld,
  input  logic [4:0] inflight_reg,
  input  logic [4:0] src1,
  input  logic [4:0] src2,
  output logic       hazard
);

  logic [NREGS-1:0] pending_q;
  logic [NREGS-1:0] pending_d;
  logic             busy1;
  logic             busy2;

  // Clear first so a set on the same register and edge wins.
  always_comb begin
    pending_d = pending_q;
    if (clr_vld) begin
      pending_d[clr_reg] = 1'b0;
    end
    if (set_vld && (set_reg != XZR)) begin
      pending_d[set_reg] = 1'b1;
    end
    pending_d[XZR] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // No write-back bypass: a register freed this cycle is only visible next cycle.
  always_comb begin
    busy1 = (src1 != XZR) &&
            (pending_q[src1] || (inflight_vld && (inflight_reg == src1)));
    busy2 = (src2 != XZR) &&
            (pending_q[src2] || (inflight_vld && (inflight_reg == src2)));
  end

  assign hazard = busy1 || busy2;

endmodule

// File: rtl/id_issue_stage.sv
// Decode/issue stage for LEGv8 R-type ALU ops: reads the RF, registers operands for EX (latency 1).
// Stalls fetch on RAW hazards and while EX holds an unaccepted instruction; flush drops EX and input.
module id_issue_stage
  import legv8_pkg::*;
(
  input  logic            clock,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic            flush,
  output logic [4:0]      Read1,
  output logic [4:0]      Read2,
  input  logic [XLEN-1:0] ReadData1,
  input  logic [XLEN-1:0] ReadData2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] ex_A,
  output logic [XLEN-1:0] ex_B,
  output logic [1:0]      ex_ALUOp,
  output logic [10:0]     ex_Opcode,
  output logic [4:0]      ex_WriteReg,
  output logic            ex_RegWrite,
  input  logic            wb_valid,
  input  logic [4:0]      wb_reg,
  output logic            illegal
);

  rtype_t          dec;
  logic            hazard;
  logic            supported;
  logic            accept;
  logic            issue;
  logic            ex_xfer;
  logic            unused_shamt;

  logic            out_valid_q, out_valid_d;
  logic            illegal_q, illegal_d;
  logic [XLEN-1:0] ex_a_q, ex_a_d;
  logic [XLEN-1:0] ex_b_q, ex_b_d;
  ex_ctrl_t        ex_ctrl_q, ex_ctrl_d;

  assign dec          = instr;
  assign Read1        = dec.rn;
  assign Read2        = dec.rm;
  // The shift amount plays no part in the register-register ops issued here.
  assign unused_shamt = ^dec.shamt;

  assign supported = is_rtype_alu(dec.opcode);
  assign in_ready  = !hazard && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready && !flush;
  assign issue     = accept && supported;
  assign ex_xfer   = out_valid_q && out_ready;

  reg_scoreboard u_scoreboard (
    .clock        (clock),
    .reset_n      (reset_n),
    .set_vld      (ex_xfer && ex_ctrl_q.reg_write),
    .set_reg      (ex_ctrl_q.write_reg),
    .clr_vld      (wb_valid),
    .clr_reg      (wb_reg),
    .inflight_vld (out_valid_q && ex_ctrl_q.reg_write),
    .inflight_reg (ex_ctrl_q.write_reg),
    .src1         (dec.rn),
    .src2         (dec.rm),
    .hazard       (hazard)
  );

  // Flush outranks a new issue; a plain transfer empties the slot unless refilled.
  always_comb begin
    out_valid_d = out_valid_q;
    illegal_d   = illegal_q;
    ex_a_d      = ex_a_q;
    ex_b_d      = ex_b_q;
    ex_ctrl_d   = ex_ctrl_q;

    if (flush) begin
      out_valid_d = 1'b0;
    end else if (issue) begin
      out_valid_d = 1'b1;
    end else if (ex_xfer) begin
      out_valid_d = 1'b0;
    end

    if (accept && !supported) begin
      illegal_d = 1'b1;
    end

    if (issue) begin
      ex_a_d              = ReadData1;
      ex_b_d              = ReadData2;
      ex_ctrl_d.opcode    = dec.opcode;
      ex_ctrl_d.alu_op    = ALUOP_RTYPE;
      ex_ctrl_d.write_reg = dec.rd;
      ex_ctrl_d.reg_write = (dec.rd != XZR);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      ex_a_q      <= '0;
      ex_b_q      <= '0;
      ex_ctrl_q   <= EX_CTRL_RST;
    end else begin
      out_valid_q <= out_valid_d;
      illegal_q   <= illegal_d;
      ex_a_q      <= ex_a_d;
      ex_b_q      <= ex_b_d;
      ex_ctrl_q   <= ex_ctrl_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign illegal     = illegal_q;
  assign ex_A        = ex_a_q;
  assign ex_B        = ex_b_q;
  assign ex_ALUOp    = ex_ctrl_q.alu_op;
  assign ex_Opcode   = ex_ctrl_q.opcode;
  assign ex_WriteReg = ex_ctrl_q.write_reg;
  assign ex_RegWrite = ex_ctrl_q.reg_write;

endmodule

// File: tb/tb_id_issue_stage.sv
// Bench for id_issue_stage: directed scenarios then randomized traffic,
// all checked against a per-register behavioural model of issue, hazards and write-back.
module tb_id_issue_stage;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        flush;
  logic [4:0]  Read1, Read2;
  logic [63:0] ReadData1, ReadData2;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] ex_A, ex_B;
  logic [1:0]  ex_ALUOp;
  logic [10:0] ex_Opcode;
  logic [4:0]  ex_WriteReg;
  logic        ex_RegWrite;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic        illegal;

  logic [63:0] rf [32];

  localparam logic [10:0] T_ADD = 11'b10001011000;
  localparam logic [10:0] T_SUB = 11'b11001011000;
  localparam logic [10:0] T_AND = 11'b10001010000;
  localparam logic [10:0] T_ORR = 11'b10101010000;
  localparam logic [63:0] V5  = 64'h5555555555555555;
  localparam logic [63:0] V10 = 64'hAAAAAAAAAAAAAAAA;
  localparam logic [63:0] V1  = 64'h0123456789ABCDEF;

  always #5 clock = ~clock;

  assign ReadData1 = rf[Read1];
  assign ReadData2 = rf[Read2];

  id_issue_stage dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instr       (instr),
    .flush       (flush),
    .Read1       (Read1),
    .Read2       (Read2),
    .ReadData1   (ReadData1),
    .ReadData2   (ReadData2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .ex_A        (ex_A),
    .ex_B        (ex_B),
    .ex_ALUOp    (ex_ALUOp),
    .ex_Opcode   (ex_Opcode),
    .ex_WriteReg (ex_WriteReg),
    .ex_RegWrite (ex_RegWrite),
    .wb_valid    (wb_valid),
    .wb_reg      (wb_reg),
    .illegal     (illegal)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state: the EX slot contents, a per-register busy table, outstanding writers.
  bit          m_ov, m_ill, m_rw;
  logic [63:0] m_a, m_b;
  logic [10:0] m_opc;
  logic [1:0]  m_alu;
  logic [4:0]  m_wr;
  bit          m_pend [32];
  logic [4:0]  wbq [$];

  function automatic bit m_supported(input logic [10:0] op);
    return (op == T_ADD) || (op == T_SUB) || (op == T_AND) || (op == T_ORR);
  endfunction

  function automatic bit m_busy(input logic [4:0] r);
    if (r == 5'd31) return 1'b0;
    return m_pend[r] || (m_ov && m_rw && (m_wr == r));
  endfunction

  function automatic bit m_in_ready();
    return !(m_busy(instr[9:5]) || m_busy(instr[20:16])) && (!m_ov || out_ready);
  endfunction

  task automatic model_reset();
    m_ov = 0; m_ill = 0; m_rw = 0;
    m_a = '0; m_b = '0; m_opc = '0; m_alu = '0; m_wr = '0;
    for (int i = 0; i < 32; i++) m_pend[i] = 0;
    wbq.delete();
  endtask

  task automatic check_all();
    chk("in_ready", in_ready, m_in_ready());
    chk("out_valid", out_valid, m_ov);
    chk("illegal", illegal, m_ill);
    chk("Read1", Read1, instr[9:5]);
    chk("Read2", Read2, instr[20:16]);
    chk("ex_A", ex_A, m_a);
    chk("ex_B", ex_B, m_b);
    chk("ex_Opcode", ex_Opcode, m_opc);
    chk("ex_ALUOp", ex_ALUOp, m_alu);
    chk("ex_WriteReg", ex_WriteReg, m_wr);
    chk("ex_RegWrite", ex_RegWrite, m_rw);
  endtask

  // Checks the current cycle at the falling edge, then advances the model across the rising edge.
  task automatic cycle();
    bit acc, sup, xfer, nov;
    @(negedge clock);
    check_all();
    sup  = m_supported(instr[31:21]);
    acc  = in_valid && m_in_ready() && !flush;
    xfer = m_ov && out_ready;
    if (wb_valid) m_pend[wb_reg] = 0;
    if (xfer && m_rw) begin
      m_pend[m_wr] = 1;
      wbq.push_back(m_wr);
    end
    if (flush)            nov = 0;
    else if (acc && sup)  nov = 1;
    else if (xfer)        nov = 0;
    else                  nov = m_ov;
    if (acc && !sup) m_ill = 1;
    if (acc && sup) begin
      m_a   = rf[instr[9:5]];
      m_b   = rf[instr[20:16]];
      m_opc = instr[31:21];
      m_alu = 2'b10;
      m_wr  = instr[4:0];
      m_rw  = (instr[4:0] != 5'd31);
    end
    m_ov = nov;
    @(posedge clock);
    #1;
  endtask

  task automatic drv(input bit v, input logic [31:0] ins, input bit fl, input bit ordy,
                     input bit wbv, input logic [4:0] wbr);
    in_valid  = v;
    instr     = ins;
    flush     = fl;
    out_ready = ordy;
    wb_valid  = wbv;
    wb_reg    = wbr;
  endtask

  task automatic reset_pulse();
    reset_n = 1'b0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_ex_A", ex_A, 0);
    chk("rst_ex_B", ex_B, 0);
    chk("rst_ex_ALUOp", ex_ALUOp, 0);
    chk("rst_ex_Opcode", ex_Opcode, 0);
    chk("rst_ex_WriteReg", ex_WriteReg, 0);
    chk("rst_ex_RegWrite", ex_RegWrite, 0);
    model_reset();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [10:0] op;
    logic [4:0]  rm, rn, rd;
    case ($urandom_range(0, 8))
      0, 1:    op = T_ADD;
      2, 3:    op = T_SUB;
      4, 5:    op = T_AND;
      6, 7:    op = T_ORR;
      default: op = 11'($urandom);
    endcase
    rm = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
    rn = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
    rd = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
    return {op, rm, 6'($urandom), rn, rd};
  endfunction

  initial begin
    for (int i = 0; i < 31; i++) rf[i] = {$urandom, $urandom};
    rf[31] = '0;
    rf[1]  = V1;
    rf[5]  = V5;
    rf[10] = V10;

    reset_n = 1'b0;
    drv(0, 32'h0, 0, 0, 0, 5'd0);
    #2;
    chk("init_out_valid", out_valid, 0);
    chk("init_illegal", illegal, 0);
    chk("init_ex_A", ex_A, 0);
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;

    // ADD X1,X5,X10: one-cycle latency and operand capture.
    drv(1, 32'h8B0A00A1, 0, 0, 0, 5'd0);
    cycle();
    drv(0, 32'h8B0A00A1, 0, 0, 0, 5'd0);
    #1;
    chk("add_out_valid", out_valid, 1);
    chk("add_ex_A", ex_A, V5);
    chk("add_ex_B", ex_B, V10);
    chk("add_ex_Opcode", ex_Opcode, T_ADD);
    chk("add_ex_ALUOp", ex_ALUOp, 2'b10);
    chk("add_ex_WriteReg", ex_WriteReg, 5'd1);
    chk("add_ex_RegWrite", ex_RegWrite, 1);

    // ORR X2,X5,X1 waits on X1 until the cycle after its write-back.
    drv(1, 32'hAA0100A2, 0, 1, 0, 5'd0);
    #1;
    chk("orr_blk_inflight", in_ready, 0);
    cycle();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("orr_blk_pending", in_ready, 0);
      cycle();
    end
    drv(1, 32'hAA0100A2, 0, 1, 1, 5'd1);
    #1;
    chk("orr_blk_wb_cycle", in_ready, 0);
    cycle();
    drv(1, 32'hAA0100A2, 0, 1, 0, 5'd0);
    #1;
    chk("orr_rdy_after_wb", in_ready, 1);
    cycle();

    // EX stall for three cycles holds the ORR, then SUB X4 issues.
    drv(1, 32'hCB0A00A4, 0, 0, 0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_out_valid", out_valid, 1);
      chk("stall_ex_Opcode", ex_Opcode, T_ORR);
      chk("stall_ex_A", ex_A, V5);
      chk("stall_ex_B", ex_B, V1);
      chk("stall_ex_WriteReg", ex_WriteReg, 5'd2);
      chk("stall_in_ready", in_ready, 0);
      cycle();
    end
    drv(1, 32'hCB0A00A4, 0, 1, 0, 5'd0);
    cycle();
    drv(0, 32'hCB0A00A4, 0, 0, 0, 5'd0);
    #1;
    chk("sub_out_valid", out_valid, 1);
    chk("sub_ex_Opcode", ex_Opcode, T_SUB);
    chk("sub_ex_WriteReg", ex_WriteReg, 5'd4);
    chk("sub_ex_B", ex_B, V10);

    // Unsupported opcode: sticky illegal, nothing issued.
    drv(1, 32'hD2800000, 0, 1, 0, 5'd0);
    cycle();
    drv(0, 32'hD2800000, 0, 1, 0, 5'd0);
    #1;
    chk("ill_set", illegal, 1);
    chk("ill_no_issue", out_valid, 0);
    cycle();
    cycle();
    chk("ill_sticky", illegal, 1);

    // Flush with EX full and input valid, then flush against an otherwise-acceptable input.
    drv(1, 32'h8B0A00A6, 0, 0, 0, 5'd0);
    cycle();
    drv(1, 32'hCB0A00A7, 1, 0, 0, 5'd0);
    cycle();
    chk("flush_out_valid", out_valid, 0);
    chk("flush_illegal_kept", illegal, 1);
    drv(1, 32'hCB0A00A7, 1, 1, 0, 5'd0);
    #1;
    chk("flush_in_ready", in_ready, 1);
    cycle();
    chk("flush_not_consumed", out_valid, 0);

    // Reset mid-stall; X2 and X4 were pending and must be free afterwards.
    drv(1, 32'h8B0A00A8, 0, 0, 0, 5'd0);
    cycle();
    drv(0, 32'h8B0A00A8, 0, 0, 0, 5'd0);
    cycle();
    reset_pulse();
    drv(1, 32'h8B040049, 0, 1, 0, 5'd0);
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    cycle();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      bit          v, fl, ordy, wbv;
      logic [4:0]  wbr;
      v    = ($urandom_range(0, 9) < 7);
      fl   = ($urandom_range(0, 15) == 0);
      ordy = ($urandom_range(0, 9) < 7);
      wbv  = 0;
      wbr  = 5'($urandom);
      if (($urandom_range(0, 2) == 0) && (wbq.size() > 0)) begin
        wbv = 1;
        wbr = wbq.pop_front();
      end else if ($urandom_range(0, 15) == 0) begin
        wbv = 1;
      end
      drv(v, rand_instr(), fl, ordy, wbv, wbr);
      if ($urandom_range(0, 399) == 0) begin
        reset_pulse();
      end else begin
        cycle();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
